// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and MEM-stage load/store
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic [1:0]    ResultSrcM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          timeout_err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SERV_D, SERV_I} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    logic w_dm_req;
    logic w_dm_elig;
    logic w_if_elig;
    logic w_abort;

    assign w_dm_req  = MemWriteM | (ResultSrcM == 2'b01);
    // The ready cycle is excluded so a request still held high is not served twice.
    assign w_dm_elig = w_dm_req & ~dm_ready;
    assign w_if_elig = if_req & ~if_ready;
    assign w_abort   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = w_dm_req & ~dm_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Data wins ties: it belongs to the older instruction.
                    if (w_dm_elig) begin
                        r_state   <= SERV_D;
                        r_cnt     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= ALUResultM;
                        mem_wdata <= WriteDataM;
                    end else if (w_if_elig) begin
                        r_state   <= SERV_I;
                        r_cnt     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                SERV_D, SERV_I: begin
                    if (mem_ack) begin
                        r_state     <= IDLE;
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b0;
                        if (r_state == SERV_D) begin
                            dm_rdata <= mem_we ? '0 : mem_rdata;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (w_abort) begin
                        r_state     <= IDLE;
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (r_state == SERV_D) begin
                            dm_rdata <= '0;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
        int          gap;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        int          delay;
    } drv_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        terr;
    } rsp_t;

    acc_t acc_q[$];
    drv_t drv_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_acc(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input int len, input int gap, input logic [31:0] rdata, input int delay);
        acc_t a;
        drv_t d;
        a.addr = addr; a.we = we; a.wdata = wdata; a.len = len; a.gap = gap;
        d.rdata = rdata; d.delay = delay;
        acc_q.push_back(a);
        drv_q.push_back(d);
    endtask

    task automatic push_rsp(input logic is_data, input logic [31:0] rdata, input logic terr);
        rsp_t r;
        r.is_data = is_data; r.rdata = rdata; r.terr = terr;
        rsp_q.push_back(r);
    endtask

    task automatic wait_ready(input logic is_data, input logic chk_stall, input string nm);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (is_data ? dm_ready : if_ready) got = 1'b1;
            else if (chk_stall) chk({nm, "_stall_wait"}, 32'(is_data ? stall_mem : stall_if), 32'd1);
        end
        chk({nm, "_ready_seen"}, 32'(got), 32'd1);
        if (got) chk({nm, "_stall_at_ready"}, 32'(is_data ? stall_mem : stall_if), 32'd0);
        @(posedge clk); #1;
    endtask

    // Memory responder: acks each new request after its scripted delay.
    initial begin
        drv_t d;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && drv_q.size() > 0) begin
                d = drv_q.pop_front();
                if (d.delay >= 0) begin
                    repeat (d.delay) begin @(posedge clk); #1; end
                    mem_ack = 1'b1;
                    mem_rdata = d.rdata;
                    @(posedge clk); #1;
                    mem_ack = 1'b0;
                    mem_rdata = '0;
                end else begin
                    for (int k = 0; k < 64 && mem_req; k++) begin @(posedge clk); #1; end
                end
            end
        end
    end

    // Monitor: memory-side accesses and requester responses against the scoreboard.
    initial begin
        acc_t cur;
        rsp_t r;
        logic m_prev;
        int   hi_cnt;
        int   low_cnt;
        m_prev = 1'b0; hi_cnt = 0; low_cnt = 100;
        cur.addr = '0; cur.we = 1'b0; cur.wdata = '0; cur.len = -1; cur.gap = -1;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!m_prev) begin
                    chk("acc_expected", 32'(acc_q.size() != 0), 32'd1);
                    if (acc_q.size() != 0) cur = acc_q.pop_front();
                    if (cur.gap >= 0) chk("acc_gap", 32'(low_cnt), 32'(cur.gap));
                    hi_cnt = 0;
                end
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_wdata", mem_wdata, cur.wdata);
                hi_cnt++;
            end else begin
                if (m_prev) begin
                    chk("mem_req_len", 32'(hi_cnt), 32'(cur.len));
                    low_cnt = 0;
                end
                low_cnt++;
            end
            m_prev = mem_req;

            if (if_ready || dm_ready) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                chk("ready_exclusive", 32'(if_ready & dm_ready), 32'd0);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("rsp_port", 32'(dm_ready), 32'(r.is_data));
                    chk("rsp_rdata", r.is_data ? dm_rdata : if_rdata, r.rdata);
                    chk("rsp_timeout_err", 32'(timeout_err), 32'(r.terr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ResultSrcM = 2'b00; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // IF only, ack in the first request cycle
        push_acc(32'h100, 1'b0, 32'h0, 1, -1, 32'h00500093, 0);
        push_rsp(1'b0, 32'h00500093, 1'b0);
        if_addr = 32'h100; if_req = 1'b1;
        wait_ready(1'b0, 1'b1, "if_only");
        if_req = 1'b0;
        @(negedge clk);
        chk("if_only_stall_after", 32'(stall_if), 32'd0);
        @(posedge clk); #1;

        // Load and fetch in the same cycle: data first, fetch one cycle later
        push_acc(32'h2000, 1'b0, 32'h0, 1, -1, 32'h11112222, 0);
        push_acc(32'h104, 1'b0, 32'h0, 2, 1, 32'h33334444, 1);
        push_rsp(1'b1, 32'h11112222, 1'b0);
        push_rsp(1'b0, 32'h33334444, 1'b0);
        ResultSrcM = 2'b01; ALUResultM = 32'h2000; WriteDataM = '0;
        if_addr = 32'h104; if_req = 1'b1;
        wait_ready(1'b1, 1'b1, "simul_data");
        ResultSrcM = 2'b00;
        wait_ready(1'b0, 1'b0, "simul_if");
        if_req = 1'b0;
        @(posedge clk); #1;

        // Store with delayed ack: data returned must read as zero
        push_acc(32'h2004, 1'b1, 32'hDEADBEEF, 4, -1, 32'h12345678, 3);
        push_rsp(1'b1, 32'h0, 1'b0);
        MemWriteM = 1'b1; ALUResultM = 32'h2004; WriteDataM = 32'hDEADBEEF;
        wait_ready(1'b1, 1'b1, "store");
        MemWriteM = 1'b0; WriteDataM = '0;
        @(posedge clk); #1;

        // Fetch dropped mid-access still completes
        push_acc(32'h400, 1'b0, 32'h0, 3, -1, 32'h0BADF00D, 2);
        push_rsp(1'b0, 32'h0BADF00D, 1'b0);
        if_addr = 32'h400; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_ready(1'b0, 1'b0, "if_flush");
        @(posedge clk); #1;

        // Load that never gets an ack, then a good fetch clears the error
        push_acc(32'h3000, 1'b0, 32'h0, 4, -1, 32'h0, -1);
        push_rsp(1'b1, 32'h0, 1'b1);
        ResultSrcM = 2'b01; ALUResultM = 32'h3000;
        wait_ready(1'b1, 1'b1, "timeout");
        ResultSrcM = 2'b00;
        @(negedge clk);
        chk("timeout_err_held", 32'(timeout_err), 32'd1);
        @(posedge clk); #1;
        push_acc(32'h200, 1'b0, 32'h0, 3, -1, 32'h0000A5A5, 2);
        push_rsp(1'b0, 32'h0000A5A5, 1'b0);
        if_addr = 32'h200; if_req = 1'b1;
        wait_ready(1'b0, 1'b1, "after_timeout");
        if_req = 1'b0;
        @(posedge clk); #1;

        // Reset during a fetch; the ack that arrives later must be ignored
        push_acc(32'h300, 1'b0, 32'h0, 1, -1, 32'h00000BAD, 5);
        if_addr = 32'h300; if_req = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_mem_req", 32'(mem_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'({mem_req, if_ready, dm_ready}), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("drv_q_drained", 32'(drv_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
